// File: rtl/commit_monitor.sv
// commit_monitor
//   Passive observer for the CPU commit interface. It checks that each
//   committed PC matches the previous commit's architectural next PC, counts
//   retired instructions, next-PC mispredictions and dropped trace records,
//   and buffers commit records in a first-word-fall-through FIFO that a host
//   drains over a valid/ready trace port. It never stalls the core.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   commit, instr,      per-instruction commit record from the core
//   commit_pc, commit_pre_pc, commit_pred_pc
//   clr                 synchronous clear of counters, flags, FIFO and FSM
//   trace_valid/ready   trace port handshake (pop on valid & ready)
//   trace_pc, trace_instr, trace_next_pc, trace_mispred   head record
//   fifo_level          number of queued records
//   instret, mispred_cnt, drop_cnt   saturating event counters
//   overflow, chain_err sticky error flags
//   err_pc, err_expect_pc   capture of the first PC-chain mismatch
//   state               00 IDLE, 01 RUN, 10 HALT
module commit_monitor #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FIFO_AW     = 3,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               commit,
  input  logic [31:0]        instr,
  input  logic [31:0]        commit_pc,
  input  logic [31:0]        commit_pre_pc,
  input  logic [31:0]        commit_pred_pc,
  input  logic               clr,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [31:0]        trace_pc,
  output logic [31:0]        trace_instr,
  output logic [31:0]        trace_next_pc,
  output logic               trace_mispred,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [31:0]        instret,
  output logic [31:0]        mispred_cnt,
  output logic [15:0]        drop_cnt,
  output logic               overflow,
  output logic               chain_err,
  output logic [31:0]        err_pc,
  output logic [31:0]        err_expect_pc,
  output logic [1:0]         state
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] HALT = 2'b10;

  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [1:0]         state_reg;
  logic [31:0]        exp_pc_reg;
  logic [31:0]        instret_reg;
  logic [31:0]        mispred_cnt_reg;
  logic [15:0]        drop_cnt_reg;
  logic               overflow_reg;
  logic               chain_err_reg;
  logic [31:0]        err_pc_reg;
  logic [31:0]        err_expect_pc_reg;
  logic [FIFO_AW-1:0] wr_ptr_reg;
  logic [FIFO_AW-1:0] rd_ptr_reg;
  logic [FIFO_AW:0]   level_reg;

  // Record storage; no reset so it maps onto distributed/block memory.
  logic [31:0] mem_pc    [FIFO_DEPTH];
  logic [31:0] mem_instr [FIFO_DEPTH];
  logic [31:0] mem_next  [FIFO_DEPTH];
  logic        mem_mis   [FIFO_DEPTH];

  logic accept;
  logic mispred;
  logic mismatch;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    accept   = commit && !clr && (state_reg != HALT);
    mispred  = (commit_pred_pc != commit_pre_pc);
    // Only RUN has a valid expected PC; the first commit out of IDLE seeds it.
    mismatch = accept && (state_reg == RUN) && (commit_pc != exp_pc_reg);
    pop      = (level_reg != '0) && trace_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    push     = accept && ((level_reg < DEPTH_L) || pop);
    drop     = accept && !push;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= IDLE;
      exp_pc_reg        <= '0;
      instret_reg       <= '0;
      mispred_cnt_reg   <= '0;
      drop_cnt_reg      <= '0;
      overflow_reg      <= 1'b0;
      chain_err_reg     <= 1'b0;
      err_pc_reg        <= '0;
      err_expect_pc_reg <= '0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      level_reg         <= '0;
    end else if (clr) begin
      state_reg         <= IDLE;
      exp_pc_reg        <= '0;
      instret_reg       <= '0;
      mispred_cnt_reg   <= '0;
      drop_cnt_reg      <= '0;
      overflow_reg      <= 1'b0;
      chain_err_reg     <= 1'b0;
      err_pc_reg        <= '0;
      err_expect_pc_reg <= '0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      level_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_reg <= RUN;
        RUN:     if (mismatch && STOP_ON_ERR) state_reg <= HALT;
        HALT:    state_reg <= HALT;
        default: state_reg <= IDLE;
      endcase

      if (accept) begin
        exp_pc_reg <= commit_pre_pc;
        if (instret_reg != '1) instret_reg <= instret_reg + 32'd1;
        if (mispred && (mispred_cnt_reg != '1)) mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
      end

      if (mismatch && !chain_err_reg) begin
        chain_err_reg     <= 1'b1;
        err_pc_reg        <= commit_pc;
        err_expect_pc_reg <= exp_pc_reg;
      end

      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      level_reg <= level_reg + 1'b1;
      else if (pop && !push) level_reg <= level_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_reg]    <= commit_pc;
      mem_instr[wr_ptr_reg] <= instr;
      mem_next[wr_ptr_reg]  <= commit_pre_pc;
      mem_mis[wr_ptr_reg]   <= mispred;
    end
  end

  // Head fields are forced to zero while empty so stale storage never leaks
  // out, including right after reset.
  always_comb begin
    trace_valid   = (level_reg != '0);
    trace_pc      = trace_valid ? mem_pc[rd_ptr_reg]    : '0;
    trace_instr   = trace_valid ? mem_instr[rd_ptr_reg] : '0;
    trace_next_pc = trace_valid ? mem_next[rd_ptr_reg]  : '0;
    trace_mispred = trace_valid ? mem_mis[rd_ptr_reg]   : 1'b0;
  end

  assign fifo_level    = level_reg;
  assign instret       = instret_reg;
  assign mispred_cnt   = mispred_cnt_reg;
  assign drop_cnt      = drop_cnt_reg;
  assign overflow      = overflow_reg;
  assign chain_err     = chain_err_reg;
  assign err_pc        = err_pc_reg;
  assign err_expect_pc = err_expect_pc_reg;
  assign state         = state_reg;

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor (FIFO_DEPTH=8, STOP_ON_ERR=1).
module tb_commit_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit;
  logic [31:0] instr;
  logic [31:0] commit_pc;
  logic [31:0] commit_pre_pc;
  logic [31:0] commit_pred_pc;
  logic        clr;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;
  logic [31:0] trace_next_pc;
  logic        trace_mispred;
  logic [3:0]  fifo_level;
  logic [31:0] instret;
  logic [31:0] mispred_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic        chain_err;
  logic [31:0] err_pc;
  logic [31:0] err_expect_pc;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  commit_monitor #(.FIFO_DEPTH(8), .FIFO_AW(3), .STOP_ON_ERR(1'b1)) dut (
    .clk(clk), .rst(rst), .commit(commit), .instr(instr),
    .commit_pc(commit_pc), .commit_pre_pc(commit_pre_pc),
    .commit_pred_pc(commit_pred_pc), .clr(clr),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_instr(trace_instr),
    .trace_next_pc(trace_next_pc), .trace_mispred(trace_mispred),
    .fifo_level(fifo_level), .instret(instret), .mispred_cnt(mispred_cnt),
    .drop_cnt(drop_cnt), .overflow(overflow), .chain_err(chain_err),
    .err_pc(err_pc), .err_expect_pc(err_expect_pc), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // One commit in one clock cycle; returns #1 after the capturing edge.
  task automatic do_commit(input logic [31:0] pc, input logic [31:0] pre, input logic [31:0] pred);
    commit         = 1'b1;
    commit_pc      = pc;
    commit_pre_pc  = pre;
    commit_pred_pc = pred;
    instr          = pc ^ 32'hA5A5_0013;
    @(posedge clk); #1;
    commit = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; commit = 1'b0; clr = 1'b0; trace_ready = 1'b0;
    instr = '0; commit_pc = '0; commit_pre_pc = '0; commit_pred_pc = '0;
    #2;
    check("rst_state",   {30'd0, state}, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_tvalid",  {31'd0, trace_valid}, 32'h0);
    check("rst_level",   {28'd0, fifo_level}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycle();

    // Straight-line chain with trace_ready held high.
    trace_ready = 1'b1;
    do_commit(32'h0, 32'h4, 32'h4);
    check("chain_head0", trace_pc, 32'h0);
    do_commit(32'h4, 32'h8, 32'h8);
    check("chain_head1", trace_pc, 32'h4);
    do_commit(32'h8, 32'hC, 32'hC);
    check("chain_head2", trace_pc, 32'h8);
    check("chain_instret", instret, 32'd3);
    check("chain_mispred", mispred_cnt, 32'd0);
    check("chain_err0",    {31'd0, chain_err}, 32'h0);
    check("chain_state",   {30'd0, state}, 32'h1);

    // Taken branch mispredicted as fall-through.
    do_commit(32'hC, 32'h10, 32'h10);
    do_commit(32'h10, 32'h40, 32'h14);
    check("mp_cnt",     mispred_cnt, 32'd1);
    check("mp_head_pc", trace_pc, 32'h10);
    check("mp_head_bit",{31'd0, trace_mispred}, 32'h1);
    check("mp_head_nxt",trace_next_pc, 32'h40);
    do_commit(32'h40, 32'h44, 32'h44);
    check("mp_tgt_err", {31'd0, chain_err}, 32'h0);
    check("mp_instret", instret, 32'd6);
    check("mp_tgt_bit", {31'd0, trace_mispred}, 32'h0);
    idle_cycle();
    check("mp_drained", {28'd0, fifo_level}, 32'h0);

    // Chain break halts the monitor.
    clr = 1'b1; idle_cycle(); clr = 1'b0;
    check("clr1_state", {30'd0, state}, 32'h0);
    do_commit(32'h8, 32'hC, 32'hC);
    do_commit(32'h20, 32'h24, 32'h24);
    check("ce_flag",  {31'd0, chain_err}, 32'h1);
    check("ce_pc",    err_pc, 32'h20);
    check("ce_exp",   err_expect_pc, 32'hC);
    check("ce_state", {30'd0, state}, 32'h2);
    check("ce_instret", instret, 32'd2);
    do_commit(32'h24, 32'h28, 32'h28);
    do_commit(32'h28, 32'h2C, 32'h2C);
    do_commit(32'h2C, 32'h30, 32'h30);
    check("halt_instret", instret, 32'd2);
    check("halt_state",   {30'd0, state}, 32'h2);
    clr = 1'b1; idle_cycle(); clr = 1'b0;
    check("clr2_instret", instret, 32'h0);
    check("clr2_err",     {31'd0, chain_err}, 32'h0);
    check("clr2_errpc",   err_pc, 32'h0);
    check("clr2_state",   {30'd0, state}, 32'h0);
    check("clr2_level",   {28'd0, fifo_level}, 32'h0);

    // clr and commit together: the commit is discarded.
    clr = 1'b1; do_commit(32'h80, 32'h84, 32'h84); clr = 1'b0;
    check("clrwin_instret", instret, 32'h0);
    check("clrwin_state",   {30'd0, state}, 32'h0);

    // Overflow: 10 commits into an 8-deep FIFO with no consumer.
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      do_commit(32'h100 + 32'(4*i), 32'h104 + 32'(4*i), 32'h104 + 32'(4*i));
    check("ovf_level",   {28'd0, fifo_level}, 32'd8);
    check("ovf_drop",    {16'd0, drop_cnt}, 32'd2);
    check("ovf_flag",    {31'd0, overflow}, 32'h1);
    check("ovf_instret", instret, 32'd10);
    check("ovf_head",    trace_pc, 32'h100);

    // Push while full with a pop in the same cycle.
    trace_ready = 1'b1;
    do_commit(32'h128, 32'h12C, 32'h12C);
    check("fullpp_level", {28'd0, fifo_level}, 32'd8);
    check("fullpp_drop",  {16'd0, drop_cnt}, 32'd2);
    check("fullpp_inst",  instret, 32'd11);

    // Drain: 0x104..0x11C survive, 0x120/0x124 were dropped, then 0x128.
    for (int i = 0; i < 8; i++) begin
      check("drain_pc", trace_pc, (i < 7) ? 32'h104 + 32'(4*i) : 32'h128);
      idle_cycle();
    end
    check("drain_valid", {31'd0, trace_valid}, 32'h0);

    // Asynchronous reset mid-stream with 5 records queued.
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      do_commit(32'h12C + 32'(4*i), 32'h130 + 32'(4*i), 32'h130 + 32'(4*i));
    check("pre_rst_level", {28'd0, fifo_level}, 32'd5);
    #2 rst = 1'b0;
    #1;
    check("arst_level",   {28'd0, fifo_level}, 32'h0);
    check("arst_valid",   {31'd0, trace_valid}, 32'h0);
    check("arst_instret", instret, 32'h0);
    check("arst_drop",    {16'd0, drop_cnt}, 32'h0);
    check("arst_ovf",     {31'd0, overflow}, 32'h0);
    check("arst_state",   {30'd0, state}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycle();
    do_commit(32'h500, 32'h504, 32'h504);
    check("post_rst_state", {30'd0, state}, 32'h1);
    check("post_rst_err",   {31'd0, chain_err}, 32'h0);
    check("post_rst_inst",  instret, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
